// File: rtl/status_uart_tx.sv
// 8N1 UART transmitter for the self-destruct status word.
// Each accepted send emits three bytes: SYNC, STATUS, CHECK (SYNC ^ STATUS).
//
// state | meaning
// IDLE  | line high, waiting for send
// START | start bit (tx low) for one bit period
// DATA  | eight data bits, LSB first
// STOP  | stop bit (tx high); then next byte or back to IDLE
module status_uart_tx #(
  parameter int unsigned CLK_DIV   = 22,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       send,
  input  logic [3:0] count,
  input  logic       danger,
  input  logic       damaged,
  input  logic       immobilized,
  input  logic       armed,
  output logic       busy,
  output logic       done,
  output logic       tx
);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  localparam logic [15:0] BAUD_LAST = 16'(CLK_DIV - 1);

  state_t      state, state_nxt;
  logic [15:0] baud_cnt, baud_nxt;
  logic [2:0]  bit_cnt, bit_nxt;
  logic [1:0]  byte_idx, byte_nxt;
  logic [7:0]  status_q, status_nxt;
  logic [7:0]  check_q, check_nxt;
  logic        tx_nxt, busy_nxt, done_nxt;
  logic [7:0]  cur_byte;
  logic [7:0]  snap;
  logic        bit_end;

  assign snap    = {armed, immobilized, damaged, danger, count};
  assign bit_end = (baud_cnt == BAUD_LAST);

  always_comb begin
    cur_byte = check_q;
    case (byte_idx)
      2'd0:    cur_byte = SYNC_BYTE;
      2'd1:    cur_byte = status_q;
      default: cur_byte = check_q;
    endcase
  end

  always_comb begin
    state_nxt  = state;
    baud_nxt   = baud_cnt;
    bit_nxt    = bit_cnt;
    byte_nxt   = byte_idx;
    status_nxt = status_q;
    check_nxt  = check_q;
    tx_nxt     = tx;
    busy_nxt   = busy;
    done_nxt   = 1'b0;

    if (state != IDLE) begin
      baud_nxt = bit_end ? 16'd0 : baud_cnt + 16'd1;
    end

    case (state)
      IDLE: begin
        // IDLE is exactly the not-busy condition, so no separate busy gate
        if (send) begin
          status_nxt = snap;
          check_nxt  = SYNC_BYTE ^ snap;
          byte_nxt   = 2'd0;
          bit_nxt    = 3'd0;
          baud_nxt   = 16'd0;
          tx_nxt     = 1'b0;
          busy_nxt   = 1'b1;
          state_nxt  = START;
        end
      end
      START: begin
        if (bit_end) begin
          state_nxt = DATA;
          bit_nxt   = 3'd0;
          tx_nxt    = cur_byte[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_cnt == 3'd7) begin
            state_nxt = STOP;
            tx_nxt    = 1'b1;
          end else begin
            bit_nxt = bit_cnt + 3'd1;
            tx_nxt  = cur_byte[bit_cnt + 3'd1];
          end
        end
      end
      STOP: begin
        if (bit_end) begin
          if (byte_idx == 2'd2) begin
            state_nxt = IDLE;
            busy_nxt  = 1'b0;
            done_nxt  = 1'b1;
          end else begin
            byte_nxt  = byte_idx + 2'd1;
            state_nxt = START;
            tx_nxt    = 1'b0;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      baud_cnt <= 16'd0;
      bit_cnt  <= 3'd0;
      byte_idx <= 2'd0;
      status_q <= 8'd0;
      check_q  <= 8'd0;
      tx       <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_nxt;
      baud_cnt <= baud_nxt;
      bit_cnt  <= bit_nxt;
      byte_idx <= byte_nxt;
      status_q <= status_nxt;
      check_q  <= check_nxt;
      tx       <= tx_nxt;
      busy     <= busy_nxt;
      done     <= done_nxt;
    end
  end

endmodule

// File: doc/status_uart_tx.md
Name: status_uart_tx

Overview:
- Serial transmitter for the self-destruct status word, sending it off-board to the host link.
- Sits beside the countdown and LED path; consumes the countdown value and the debounced danger/damaged/immobilized/armed levels.
- On each accepted send request, captures a snapshot of those inputs and emits a 3-byte 8N1 UART frame: SYNC, STATUS, CHECK.
- Host-side receiver and decoding are out of scope.

Parameters:
- CLK_DIV, 22, clk cycles per UART bit (2.5 MHz / 115200 ≈ 22); legal range 2..65535.
- SYNC_BYTE, 8'hA5, first byte of every frame.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- send  input  1  transmit request; sampled every clk; accepted only when busy==0.
- count  input  4  countdown value; captured on acceptance.
- danger  input  1  debounced danger level; captured on acceptance.
- damaged  input  1  debounced damaged level; captured on acceptance.
- immobilized  input  1  debounced immobilized level; captured on acceptance.
- armed  input  1  self-destruct armed level; captured on acceptance.
- busy  output  1  high from the cycle after acceptance until frame completion.
- done  output  1  one-cycle pulse on frame completion.
- tx  output  1  UART line; idles high.

Behaviour:
- Reset (async assert, rst_n low):
  - tx=1, busy=0, done=0; FSM returns to IDLE; snapshot cleared to 0.
  - Applies immediately, including mid-frame; the partial frame is abandoned and never resumed.
  - Reset release is synchronous to clk; the first send is accepted on the first rising edge with rst_n high.
- Acceptance:
  - Occurs on a rising edge where send==1 and busy==0.
  - On that edge, register STATUS = {armed, immobilized, damaged, danger, count[3:0]} (bit7..bit0) and CHECK = SYNC_BYTE ^ STATUS.
  - send while busy==1 is ignored; it is not queued.
- FSM states and transitions:
  - IDLE -> START on acceptance. busy and tx update on the same edge: tx=0, busy=1.
  - START: tx=0 for CLK_DIV cycles -> DATA.
  - DATA: 8 bits, LSB first, each held CLK_DIV cycles -> STOP.
  - STOP: tx=1 for CLK_DIV cycles. Then byte index 0 -> 1 -> 2 selects SYNC, STATUS, CHECK; if index<2, increment and go to START, else go to IDLE.
- Frame timing:
  - Total frame length is 30*CLK_DIV cycles from the first tx=0 to the end of the last stop bit.
  - There is no idle gap between bytes.
- Completion:
  - On the edge ending the third stop bit: busy=0 and done=1 together, for exactly 1 cycle; tx stays 1.
  - A send high in the done cycle is accepted on the next edge, and its start bit follows immediately.
- Counters:
  - Baud counter: 16 bit, counts 0..CLK_DIV-1 and wraps. It resets to 0 on acceptance and at every bit boundary.
  - Bit counter: 3 bit. Byte index: 2 bit.
  - No other wrap-around is reachable.
- Input changes during busy do not affect the frame in flight.
- tx is registered: no combinational path from any input to tx.

Test Plan:
- Reset then send pulse with count=4'h5, danger=1, others=0, CLK_DIV=4:
  - tx low 1 edge after acceptance.
  - Bytes decode A5, 15, B0.
  - busy high for 120 cycles; done pulses once for 1 cycle.
- All flags=1, count=4'hF:
  - STATUS=FF, CHECK=5A.
  - Per-bit hold exactly CLK_DIV cycles measured on tx edges.
- send held high continuously:
  - Back-to-back frames, one idle cycle (the done cycle) between the last stop bit and the next start.
  - Inputs changed mid-frame appear only in the next frame.
- send pulses while busy:
  - No effect on the frame in flight; no extra frame is sent.
  - Exactly one done pulse per accepted send.
- rst_n low during DATA of the STATUS byte:
  - tx=1 and busy=0 asynchronously, before the next clk edge.
  - After release, a new send produces a complete, correct frame.
- CLK_DIV=2 edge case with count=0, flags=0:
  - Frame A5, 00, A5.
  - 60-cycle busy window.
